// File: rtl/uart_alu_cmd_sender.sv
// uart_alu_cmd_sender
//   Host side of the UART calculator link. On an accepted start it captures
//   two operands and an ALU command, then sends them as a 5-byte frame through
//   the uart_basic transmitter. The frame is OP1 low byte, OP1 high byte,
//   OP2 low byte, OP2 high byte, then {6'b0, alu_ctrl}. After the frame it
//   waits for the 2-byte result, low byte first. Each result byte has its own
//   timeout window.
//
// Parameters
//   TIMEOUT_CYCLES : clk cycles allowed per result byte before timeout_err
//   N_BITS         : operand/result width; the framing assumes 16
//
// Ports
//   clk, reset     : clock; synchronous active-high reset
//   start          : 1-cycle request, honoured only when idle and not busy
//   op1, op2       : operands, captured on an accepted start
//   alu_ctrl       : ALU command, captured on an accepted start
//   busy           : high from the accepted start through the done/timeout pulse
//   done           : 1-cycle pulse; result holds the new value
//   timeout_err    : 1-cycle pulse; a result byte did not arrive in time
//   result         : last received result; held until the next done
//   tx_start       : 1-cycle send request to uart_basic
//   tx_data        : byte to send; stable while tx_start is high
//   tx_busy        : uart_basic transmitter busy
//   rx_data        : received byte from uart_basic
//   rx_ready       : 1-cycle pulse; rx_data is valid
module uart_alu_cmd_sender #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned N_BITS         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] op1,
    input  logic [N_BITS-1:0] op2,
    input  logic [1:0]        alu_ctrl,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [N_BITS-1:0] result,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_WAIT,
        S_TX_ARM,
        S_TX_DRAIN,
        S_RX_LO,
        S_RX_HI
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] op1_q, op1_d;
    logic [N_BITS-1:0] op2_q, op2_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        res_lo_q, res_lo_d;
    logic [N_BITS-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        frame_byte;

    // Byte of the outgoing frame selected by the current index (LSB first).
    always_comb begin
        case (idx_q)
            3'd0:    frame_byte = op1_q[7:0];
            3'd1:    frame_byte = op1_q[15:8];
            3'd2:    frame_byte = op2_q[7:0];
            3'd3:    frame_byte = op2_q[15:8];
            default: frame_byte = {6'b0, ctrl_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op1_q      <= '0;
            op2_q      <= '0;
            ctrl_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            res_lo_q   <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            ctrl_q     <= ctrl_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            res_lo_q   <= res_lo_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        ctrl_d     = ctrl_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        res_lo_d   = res_lo_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            S_IDLE: begin
                // busy_q is still high during the done/timeout pulse cycle.
                // A start in that cycle is ignored, and busy then drops.
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    op1_d   = op1;
                    op2_d   = op2;
                    ctrl_d  = alu_ctrl;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (!tx_busy) begin
                    tx_data_d  = frame_byte;
                    tx_start_d = 1'b1;
                    state_d    = S_TX_ARM;
                end
            end
            // uart_basic raises tx_busy only after it sees tx_start. This guard
            // cycle keeps the drain check from treating that gap as completion.
            S_TX_ARM: begin
                state_d = S_TX_DRAIN;
            end
            S_TX_DRAIN: begin
                if (!tx_busy) begin
                    if (idx_q == 3'd4) begin
                        cnt_d   = '0;
                        state_d = S_RX_LO;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_TX_WAIT;
                    end
                end
            end
            // A byte that arrives on the terminal-count cycle is still accepted.
            S_RX_LO: begin
                if (rx_ready) begin
                    res_lo_d = rx_data;
                    cnt_d    = '0;
                    state_d  = S_RX_HI;
                end else if (cnt_q == CNT_TC) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RX_HI: begin
                if (rx_ready) begin
                    result_d = {rx_data, res_lo_q};
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (cnt_q == CNT_TC) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign result      = result_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

endmodule
